// File: rtl/sound_pkg.sv
// Shared types and constants for the tune sequencer.
// Tune id doubles as arbitration priority.
package sound_pkg;

  localparam int DUR_W     = 4;
  localparam int MAX_STEPS = 8;
  localparam int STEP_W    = $clog2(MAX_STEPS);
  localparam int NOTE_W    = 4;

  localparam logic [NOTE_W-1:0] NOTE_SILENT = '0;

  typedef enum logic [2:0] {
    SHOT   = 3'd0,
    INVHIT = 3'd1,
    START  = 3'd2,
    END    = 3'd3,
    PLRHIT = 3'd4
  } tune_t;

  typedef logic [STEP_W-1:0] step_t;

  typedef struct packed {
    logic              last;
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  dur;
  } rom_word_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_GAP
  } state_t;

  function automatic rom_word_t mk_note(
    input logic lst,
    input int   nt,
    input int   d
  );
    rom_word_t w;
    w.last = lst;
    w.note = NOTE_W'(nt);
    w.dur  = DUR_W'(d);
    return w;
  endfunction

endpackage

// File: rtl/sound_tune_rom.sv
// Tune ROM, one registered read per cycle.
// Word layout: {last, note, dur}.
module sound_tune_rom
  import sound_pkg::*;
(
  input  logic      clk,
  input  logic      resetN,
  input  tune_t     i_tune,
  input  step_t     i_step,
  output rom_word_t o_word
);

  rom_word_t w_word;
  rom_word_t r_word;

  // Tune table lookup by {tune, step}
  always_comb begin
    w_word = '0;
    case (i_tune)
      SHOT: begin
        if (i_step == 3'd0)
          w_word = mk_note(1'b1, 12, 1);
      end
      INVHIT: begin
        case (i_step)
          3'd0:    w_word = mk_note(1'b0, 9, 1);
          3'd1:    w_word = mk_note(1'b1, 5, 1);
          default: w_word = '0;
        endcase
      end
      START: begin
        case (i_step)
          3'd0:    w_word = mk_note(1'b0, 7, 2);
          3'd1:    w_word = mk_note(1'b0, 7, 2);
          3'd2:    w_word = mk_note(1'b0, 2, 2);
          3'd3:    w_word = mk_note(1'b0, 3, 2);
          3'd4:    w_word = mk_note(1'b0, 9, 2);
          3'd5:    w_word = mk_note(1'b0, 9, 2);
          3'd6:    w_word = mk_note(1'b0, 5, 2);
          default: w_word = mk_note(1'b1, 7, 2);
        endcase
      end
      END: begin
        case (i_step)
          3'd0:    w_word = mk_note(1'b0, 5, 4);
          3'd1:    w_word = mk_note(1'b0, 4, 4);
          3'd2:    w_word = mk_note(1'b0, 3, 4);
          3'd3:    w_word = mk_note(1'b0, 2, 4);
          3'd4:    w_word = mk_note(1'b1, 1, 4);
          default: w_word = '0;
        endcase
      end
      PLRHIT: begin
        case (i_step)
          3'd0:    w_word = mk_note(1'b0, 3, 3);
          3'd1:    w_word = mk_note(1'b0, 2, 3);
          3'd2:    w_word = mk_note(1'b1, 1, 3);
          default: w_word = '0;
        endcase
      end
      default: w_word = '0;
    endcase
  end

  // Registered read port
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      r_word <= '0;
    else
      r_word <= w_word;
  end

  assign o_word = r_word;

endmodule

// File: rtl/sound_sequencer.sv
// Game sound sequencer: priority arbiter with
// preemption, tune stepping on the tick strobe.
module sound_sequencer
  import sound_pkg::*;
(
  input  logic        clk,
  input  logic        resetN,
  input  logic        tick,
  input  logic        mute,
  input  logic        reqPlrHit,
  input  logic        reqEnd,
  input  logic        reqStart,
  input  logic        reqInvHit,
  input  logic        reqShot,
  output logic [3:0]  sndOut,
  output logic        busy,
  output logic [2:0]  tuneId,
  output logic        done
);

  state_t           r_state;
  state_t           w_state_nxt;
  tune_t            r_tune;
  tune_t            w_tune_nxt;
  tune_t            w_win;
  step_t            r_step;
  step_t            w_step_nxt;
  logic [DUR_W-1:0] r_cnt;
  logic [DUR_W-1:0] w_cnt_nxt;
  logic [DUR_W-1:0] w_cnt_inc;
  logic [DUR_W-1:0] w_dur_eff;
  logic             w_req;
  logic             w_grant;
  logic             w_last;
  logic             w_end_note;
  logic             w_done;
  rom_word_t        w_rom;

  // ROM is addressed by next-state values so its
  // registered output always matches r_tune/r_step.
  sound_tune_rom u_rom (
    .clk    (clk),
    .resetN (resetN),
    .i_tune (w_tune_nxt),
    .i_step (w_step_nxt),
    .o_word (w_rom)
  );

  assign w_dur_eff  = (w_rom.dur == '0) ? DUR_W'(1)
                                         : w_rom.dur;
  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_end_note = tick && (w_cnt_inc >= w_dur_eff);
  assign w_last     = w_rom.last ||
                      (r_step == step_t'(MAX_STEPS-1));

  // Fixed-priority winner; grant needs strictly higher
  // priority than the active tune unless idle.
  always_comb begin
    w_req = 1'b1;
    w_win = SHOT;
    priority case (1'b1)
      reqPlrHit: w_win = PLRHIT;
      reqEnd:    w_win = END;
      reqStart:  w_win = START;
      reqInvHit: w_win = INVHIT;
      reqShot:   w_win = SHOT;
      default:   w_req = 1'b0;
    endcase
    w_grant = w_req &&
              ((r_state == S_IDLE) || (w_win > r_tune));
  end

  // Next-state logic; a grant overrides any tick.
  always_comb begin
    w_state_nxt = r_state;
    w_tune_nxt  = r_tune;
    w_step_nxt  = r_step;
    w_cnt_nxt   = r_cnt;
    w_done      = 1'b0;
    if (w_grant) begin
      w_state_nxt = S_LOAD;
      w_tune_nxt  = w_win;
      w_step_nxt  = '0;
      w_cnt_nxt   = '0;
    end else begin
      unique case (r_state)
        S_IDLE: ;
        S_LOAD: begin
          w_state_nxt = S_PLAY;
          w_cnt_nxt   = '0;
        end
        S_PLAY: begin
          if (w_end_note) begin
            w_cnt_nxt = '0;
            if (w_last) begin
              w_state_nxt = S_IDLE;
              w_done      = 1'b1;
            end else begin
              w_state_nxt = S_GAP;
            end
          end else if (tick) begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        S_GAP: begin
          if (tick) begin
            w_state_nxt = S_PLAY;
            w_step_nxt  = r_step + 1'b1;
            w_cnt_nxt   = '0;
          end
        end
      endcase
    end
  end

  // State, tune, step and tick counter registers
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= S_IDLE;
      r_tune  <= SHOT;
      r_step  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tune  <= w_tune_nxt;
      r_step  <= w_step_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign sndOut = ((r_state == S_PLAY) && !mute)
                  ? w_rom.note : NOTE_SILENT;
  assign busy   = (r_state != S_IDLE);
  assign tuneId = r_tune;
  assign done   = w_done;

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed bench for sound_sequencer: records sndOut
// as (value, run length) segments per tune.
module tb_sound_sequencer;

  localparam logic [4:0] R_SHOT  = 5'b00001;
  localparam logic [4:0] R_INV   = 5'b00010;
  localparam logic [4:0] R_START = 5'b00100;
  localparam logic [4:0] R_END   = 5'b01000;
  localparam logic [4:0] R_PLR   = 5'b10000;
  localparam int         BUDGET  = 600;

  logic       clk;
  logic       resetN;
  logic       tick;
  logic       mute;
  logic       reqPlrHit;
  logic       reqEnd;
  logic       reqStart;
  logic       reqInvHit;
  logic       reqShot;
  logic [3:0] sndOut;
  logic       busy;
  logic [2:0] tuneId;
  logic       done;

  int n_chk;
  int n_err;
  int cyc;
  int n_done;
  int obs_v[$];
  int obs_l[$];
  int want_v[$];
  int want_l[$];

  sound_sequencer dut (
    .clk       (clk),
    .resetN    (resetN),
    .tick      (tick),
    .mute      (mute),
    .reqPlrHit (reqPlrHit),
    .reqEnd    (reqEnd),
    .reqStart  (reqStart),
    .reqInvHit (reqInvHit),
    .reqShot   (reqShot),
    .sndOut    (sndOut),
    .busy      (busy),
    .tuneId    (tuneId),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input int obs, input int want);
    n_chk++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               tag, obs, want);
    end
  endtask

  // One cycle: drive inputs 1 time unit after posedge
  task automatic step(input logic [4:0] r);
    @(posedge clk);
    #1;
    cyc++;
    tick = ((cyc % 10) == 0);
    {reqPlrHit, reqEnd, reqStart, reqInvHit, reqShot} = r;
  endtask

  task automatic ex(input int v, input int l);
    want_v.push_back(v);
    want_l.push_back(l);
  endtask

  task automatic build(input int nt[8], input int n,
                       input int d);
    want_v.delete();
    want_l.delete();
    ex(0, 1);
    for (int i = 0; i < n; i++) begin
      if (i > 0) ex(0, 10);
      ex(nt[i], 10 * d);
    end
  endtask

  // Request r0 at a cycle with cyc%10==9, then optional
  // injections at relative cycles k0/k1; record until idle.
  task automatic play(input string tag,
                      input logic [4:0] r0,
                      input int k0, input logic [4:0] q0,
                      input int k1, input logic [4:0] q1);
    int cv;
    int cl;
    int k;
    logic [4:0] r;
    obs_v.delete();
    obs_l.delete();
    n_done = 0;
    while (((cyc + 1) % 10) != 9) step(5'b0);
    step(r0);
    cv = -1;
    cl = 0;
    for (k = 1; k <= BUDGET; k++) begin
      r = (k == k0) ? q0 : ((k == k1) ? q1 : 5'b0);
      step(r);
      @(negedge clk);
      if (!busy) break;
      n_done += int'(done);
      if (int'(sndOut) == cv) begin
        cl++;
      end else begin
        if (cl > 0) begin
          obs_v.push_back(cv);
          obs_l.push_back(cl);
        end
        cv = int'(sndOut);
        cl = 1;
      end
    end
    if (cl > 0) begin
      obs_v.push_back(cv);
      obs_l.push_back(cl);
    end
    if (k > BUDGET) chk({tag, "_timeout"}, 1, 0);
    step(5'b0);
  endtask

  task automatic cmp(input string tag);
    chk({tag, "_nseg"}, obs_v.size(), want_v.size());
    for (int i = 0; i < want_v.size() &&
                    i < obs_v.size(); i++) begin
      chk($sformatf("%s_val%0d", tag, i),
          obs_v[i], want_v[i]);
      chk($sformatf("%s_len%0d", tag, i),
          obs_l[i], want_l[i]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clk = 1'b0;
    resetN = 1'b0;
    tick = 1'b0;
    mute = 1'b0;
    {reqPlrHit, reqEnd, reqStart, reqInvHit, reqShot} = '0;
    n_chk = 0;
    n_err = 0;
    cyc = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_snd", sndOut, 0);
    chk("rst_busy", busy, 0);
    chk("rst_id", tuneId, 0);
    chk("rst_done", done, 0);
    resetN = 1'b1;

    // Shot: 12 for one tick
    play("shot", R_SHOT, 0, 5'b0, 0, 5'b0);
    build('{12, 0, 0, 0, 0, 0, 0, 0}, 1, 1);
    cmp("shot");
    chk("shot_done", n_done, 1);
    chk("shot_busy", busy, 0);
    chk("shot_id", tuneId, 0);

    // Start jingle, 8 notes of 2 ticks
    play("start", R_START, 0, 5'b0, 0, 5'b0);
    build('{7, 7, 2, 3, 9, 9, 5, 7}, 8, 2);
    cmp("start");
    chk("start_done", n_done, 1);
    chk("start_id", tuneId, 2);

    // Start preempted by plrHit during note 3
    play("pre", R_START, 65, R_PLR, 0, 5'b0);
    want_v.delete();
    want_l.delete();
    ex(0, 1);  ex(7, 20); ex(0, 10); ex(7, 20);
    ex(0, 10); ex(2, 4);  ex(0, 1);  ex(3, 25);
    ex(0, 10); ex(2, 30); ex(0, 10); ex(1, 30);
    cmp("pre");
    chk("pre_done", n_done, 1);
    chk("pre_id", tuneId, 4);

    // InvHit: lower shot dropped, equal re-request ignored
    play("inv", R_INV, 3, R_SHOT, 15, R_INV);
    build('{9, 5, 0, 0, 0, 0, 0, 0}, 2, 1);
    cmp("inv");
    chk("inv_done", n_done, 1);
    chk("inv_id", tuneId, 1);

    // Shot and end together: end wins
    play("end", R_SHOT | R_END, 0, 5'b0, 0, 5'b0);
    build('{5, 4, 3, 2, 1, 0, 0, 0}, 5, 4);
    cmp("end");
    chk("end_done", n_done, 1);
    chk("end_id", tuneId, 3);

    // Same with mute: silent, identical timing
    mute = 1'b1;
    play("mute", R_SHOT | R_END, 0, 5'b0, 0, 5'b0);
    mute = 1'b0;
    want_v.delete();
    want_l.delete();
    ex(0, 241);
    cmp("mute");
    chk("mute_done", n_done, 1);
    chk("mute_id", tuneId, 3);

    // Reset in the middle of the end tune
    while (((cyc + 1) % 10) != 9) step(5'b0);
    step(R_END);
    repeat (20) step(5'b0);
    @(negedge clk);
    chk("mid_snd", sndOut, 5);
    chk("mid_busy", busy, 1);
    chk("mid_id", tuneId, 3);
    step(5'b0);
    resetN = 1'b0;
    #1;
    chk("arst_snd", sndOut, 0);
    chk("arst_busy", busy, 0);
    chk("arst_id", tuneId, 0);
    chk("arst_done", done, 0);
    step(5'b0);
    resetN = 1'b1;

    // Shot after reset plays normally
    play("shot2", R_SHOT, 0, 5'b0, 0, 5'b0);
    build('{12, 0, 0, 0, 0, 0, 0, 0}, 1, 1);
    cmp("shot2");
    chk("shot2_done", n_done, 1);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
